// File: rtl/cep_define.sv
// Shared PMP definitions: cfg byte layout, address-matching modes, access types,
// privilege encodings and CSR numbers used by the scan unit and its matcher.
package cep_define;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } pmp_amode_e;

  typedef enum logic [1:0] {
    OPER_READ    = 2'b00,
    OPER_WRITE   = 2'b01,
    OPER_EXECUTE = 2'b10
  } pmp_oper_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_RESP = 2'b10
  } scan_state_e;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_amode_e a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;

  localparam logic [1:0]  PRIV_U = 2'b00;
  localparam logic [1:0]  PRIV_S = 2'b01;
  localparam logic [1:0]  PRIV_M = 2'b11;

  localparam logic [31:0] CSR_PMPCFG0  = 32'h0000_03A0;
  localparam logic [31:0] CSR_PMPADDR0 = 32'h0000_03B0;

  localparam int IDX_W = 4;

  // Write-only (R=0, W=1) is not a legal permission pair, so it collapses to no access.
  function automatic pmpcfg_t pmpcfg_warl(input logic [7:0] v);
    pmpcfg_t c;
    c = pmpcfg_t'(v);
    if (!c.r && c.w) c.w = 1'b0;
    return c;
  endfunction

  function automatic logic pmp_perm(input pmpcfg_t c, input logic [1:0] oper);
    logic p;
    case (oper)
      OPER_READ:    p = c.r;
      OPER_WRITE:   p = c.w;
      OPER_EXECUTE: p = c.x;
      default:      p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational region check of one PMP entry against an access of 1/2/4 bytes;
// reports a full match (both ends inside) or a partial match (exactly one end inside).
module pmp_entry_match
  import cep_define::*;
(
  input  pmpcfg_t     i_cfg,
  input  logic [29:0] i_pmpaddr_prev,
  input  logic [29:0] i_pmpaddr,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  output logic        o_match,
  output logic        o_partial
);

  logic [31:0] w_last_addr;
  logic [29:0] w_napot_mask;
  logic        w_first_in;
  logic        w_last_in;

  function automatic logic in_region(input pmp_amode_e  mode,
                                     input logic [29:0] prev,
                                     input logic [29:0] cur,
                                     input logic [29:0] mask,
                                     input logic [31:0] a);
    logic hit;
    case (mode)
      PMP_TOR:   hit = (a >= {prev, 2'b00}) && (a < {cur, 2'b00});
      PMP_NA4:   hit = (a[31:2] == cur);
      PMP_NAPOT: hit = (((a[31:2] ^ cur) & ~mask) == 30'd0);
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    w_last_addr  = i_addr + ((32'd1 << i_size) - 32'd1);
    // Trailing ones plus the first zero above them form the don't-care word bits.
    w_napot_mask = i_pmpaddr ^ (i_pmpaddr + 30'd1);
    w_first_in   = in_region(i_cfg.a, i_pmpaddr_prev, i_pmpaddr, w_napot_mask, i_addr);
    w_last_in    = in_region(i_cfg.a, i_pmpaddr_prev, i_pmpaddr, w_napot_mask, w_last_addr);
    o_match      = w_first_in && w_last_in;
    o_partial    = w_first_in ^ w_last_in;
  end

endmodule

// File: rtl/pmp_scan_unit.sv
// PMP checker: CSR-programmable cfg/address registers and a sequential scanner that
// walks the entries one per cycle and returns the first-match permission verdict.
module pmp_scan_unit
  import cep_define::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [31:0]      rw_addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      addr,
  input  logic [1:0]       size,
  input  logic [1:0]       oper,
  input  logic [1:0]       priv_mode,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_allow,
  output logic             resp_hit,
  output logic [IDX_W-1:0] resp_idx
);

  localparam int               NUM_CFG_REGS = NUM_ENTRIES / 4;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_ENTRIES - 1);

  pmpcfg_t                r_cfg     [NUM_ENTRIES];
  logic [29:0]            r_pmpaddr [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] w_lock;
  logic [NUM_ENTRIES-1:0] w_tor_lock;
  logic [NUM_ENTRIES-1:0] w_addr_lock;
  logic [31:0]            w_rdata;
  logic [31:0]            r_rdata;

  scan_state_e      r_state;
  scan_state_e      w_state_next;
  logic [31:0]      r_req_addr;
  logic [1:0]       r_req_size;
  logic [1:0]       r_req_oper;
  logic [1:0]       r_req_priv;
  logic [IDX_W-1:0] r_idx;

  logic             r_eval_vld;
  logic             r_eval_match;
  logic             r_eval_partial;
  logic             r_eval_allow;
  logic [IDX_W-1:0] r_eval_idx;

  logic             r_resp_allow;
  logic             r_resp_hit;
  logic [IDX_W-1:0] r_resp_idx;

  logic             w_req_bad;
  logic             w_resp_load;
  logic             w_resp_allow;
  logic             w_resp_hit;
  logic [IDX_W-1:0] w_resp_idx;

  pmpcfg_t          w_cur_cfg;
  logic [29:0]      w_cur_addr;
  logic [29:0]      w_prev_addr;
  logic             w_match;
  logic             w_partial;
  logic             w_cur_allow;

  // An address register is frozen by its own lock, or by the next entry when that
  // entry is a locked TOR region using it as the lower bound.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_lock[i]     = r_cfg[i].l;
      w_tor_lock[i] = r_cfg[i].l && (r_cfg[i].a == PMP_TOR);
    end
    w_addr_lock = w_lock | (w_tor_lock >> 1);
  end

  // NOTE: the cfg/address arrays are architectural state whose lock bits must clear,
  // so every element is reset rather than left as uninitialised storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_cfg[i]     <= '0;
        r_pmpaddr[i] <= '0;
      end
    end else if (wr_en) begin
      for (int k = 0; k < NUM_CFG_REGS; k++) begin
        if (rw_addr == CSR_PMPCFG0 + 32'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (!r_cfg[4*k+b].l) r_cfg[4*k+b] <= pmpcfg_warl(wdata[8*b +: 8]);
          end
        end
      end
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if ((rw_addr == CSR_PMPADDR0 + 32'(i)) && !w_addr_lock[i]) begin
          r_pmpaddr[i] <= wdata[29:0];
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < NUM_CFG_REGS; k++) begin
      if (rw_addr == CSR_PMPCFG0 + 32'(k)) begin
        w_rdata = {r_cfg[4*k+3], r_cfg[4*k+2], r_cfg[4*k+1], r_cfg[4*k]};
      end
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (rw_addr == CSR_PMPADDR0 + 32'(i)) w_rdata = {2'b00, r_pmpaddr[i]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset)      r_rdata <= '0;
    else if (rd_en) r_rdata <= w_rdata;
  end

  always_comb begin
    w_cur_cfg   = '0;
    w_cur_addr  = '0;
    w_prev_addr = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_cfg  = r_cfg[i];
        w_cur_addr = r_pmpaddr[i];
      end
      if ((i < NUM_ENTRIES - 1) && (r_idx == IDX_W'(i + 1))) w_prev_addr = r_pmpaddr[i];
    end
    w_cur_allow = ((r_req_priv == PRIV_M) && !w_cur_cfg.l) ? 1'b1
                                                           : pmp_perm(w_cur_cfg, r_req_oper);
  end

  pmp_entry_match u_match (
    .i_cfg          (w_cur_cfg),
    .i_pmpaddr_prev (w_prev_addr),
    .i_pmpaddr      (w_cur_addr),
    .i_addr         (r_req_addr),
    .i_size         (r_req_size),
    .o_match        (w_match),
    .o_partial      (w_partial)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Decisions in SCAN use the registered result of the previous cycle's entry.
  always_comb begin
    w_state_next = r_state;
    w_resp_load  = 1'b0;
    w_resp_allow = 1'b0;
    w_resp_hit   = 1'b0;
    w_resp_idx   = '0;
    w_req_bad    = (r_req_size == 2'd3) ||
                   !((r_req_oper == OPER_READ) || (r_req_oper == OPER_WRITE) ||
                     (r_req_oper == OPER_EXECUTE));
    case (r_state)
      ST_IDLE: if (req_valid) w_state_next = ST_SCAN;
      ST_SCAN: begin
        if (w_req_bad) begin
          w_state_next = ST_RESP;
          w_resp_load  = 1'b1;
        end else if (r_eval_vld && (r_eval_match || r_eval_partial)) begin
          w_state_next = ST_RESP;
          w_resp_load  = 1'b1;
          w_resp_hit   = 1'b1;
          w_resp_allow = r_eval_match && r_eval_allow;
          w_resp_idx   = r_eval_idx;
        end else if (r_eval_vld && (r_eval_idx == LAST_IDX)) begin
          w_state_next = ST_RESP;
          w_resp_load  = 1'b1;
          w_resp_allow = (r_req_priv == PRIV_M);
        end
      end
      ST_RESP: if (resp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_addr     <= '0;
      r_req_size     <= '0;
      r_req_oper     <= '0;
      r_req_priv     <= '0;
      r_idx          <= '0;
      r_eval_vld     <= 1'b0;
      r_eval_match   <= 1'b0;
      r_eval_partial <= 1'b0;
      r_eval_allow   <= 1'b0;
      r_eval_idx     <= '0;
      r_resp_allow   <= 1'b0;
      r_resp_hit     <= 1'b0;
      r_resp_idx     <= '0;
    end else begin
      if ((r_state == ST_IDLE) && req_valid) begin
        r_req_addr <= addr;
        r_req_size <= size;
        r_req_oper <= oper;
        r_req_priv <= priv_mode;
        r_idx      <= '0;
        r_eval_vld <= 1'b0;
      end else if ((r_state == ST_SCAN) && !w_req_bad) begin
        r_eval_vld     <= 1'b1;
        r_eval_match   <= w_match;
        r_eval_partial <= w_partial;
        r_eval_allow   <= w_cur_allow;
        r_eval_idx     <= r_idx;
        if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
      end
      if (w_resp_load) begin
        r_resp_allow <= w_resp_allow;
        r_resp_hit   <= w_resp_hit;
        r_resp_idx   <= w_resp_idx;
      end
    end
  end

  assign rdata      = r_rdata;
  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_allow = r_resp_allow;
  assign resp_hit   = r_resp_hit;
  assign resp_idx   = r_resp_idx;

endmodule

// File: tb/tb_pmp_scan_unit.sv
// Scoreboard bench for pmp_scan_unit: directed CSR and access vectors push expected
// results into queues; a monitor compares whenever rdata or a response is presented.
module tb_pmp_scan_unit;
  import cep_define::*;

  typedef struct {
    logic       allow;
    logic       hit;
    logic [3:0] idx;
    int         lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rw_addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr = '0;
  logic [1:0]  size = '0;
  logic [1:0]  oper = '0;
  logic [1:0]  priv_mode = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_allow;
  logic        resp_hit;
  logic [3:0]  resp_idx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t        exp_q[$];
  logic [31:0] csr_q[$];

  pmp_scan_unit #(.NUM_ENTRIES(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .rw_addr    (rw_addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .addr       (addr),
    .size       (size),
    .oper       (oper),
    .priv_mode  (priv_mode),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_allow (resp_allow),
    .resp_hit   (resp_hit),
    .resp_idx   (resp_idx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: all DUT outputs are sampled on the falling edge.
  bit   was_valid = 1'b0;
  bit   rd_pend   = 1'b0;
  int   acc_cyc   = 0;
  exp_t cur_e;
  logic [31:0] cur_c;

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (reset) begin
        was_valid = 1'b0;
        rd_pend   = 1'b0;
      end else begin
        if (rd_pend) begin
          if (csr_q.size() == 0) begin
            check(1'b0, "csr_unexpected", rdata, 32'h0);
          end else begin
            cur_c = csr_q.pop_front();
            check(rdata == cur_c, "csr_rdata", rdata, cur_c);
          end
        end
        rd_pend = rd_en;
        if (req_valid && req_ready) acc_cyc = cyc + 1;
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "resp_unexpected", 32'(resp_valid), 32'h0);
          end else begin
            cur_e = exp_q[0];
            if (!was_valid) check((cyc - acc_cyc) == cur_e.lat, "resp_latency",
                                  32'(cyc - acc_cyc), 32'(cur_e.lat));
            check(resp_allow == cur_e.allow, "resp_allow", 32'(resp_allow), 32'(cur_e.allow));
            check(resp_hit == cur_e.hit, "resp_hit", 32'(resp_hit), 32'(cur_e.hit));
            if (cur_e.hit) check(resp_idx == cur_e.idx, "resp_idx", 32'(resp_idx), 32'(cur_e.idx));
            if (resp_ready) void'(exp_q.pop_front());
          end
        end
        was_valid = resp_valid && !resp_ready;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (((exp_q.size() != 0) || (csr_q.size() != 0)) && (n < 100)) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check(1'b0, "drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic csr_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    wr_en = 1'b1; rw_addr = a; wdata = d;
    @(posedge clock); #1;
    wr_en = 1'b0;
  endtask

  task automatic csr_read(input logic [31:0] a, input logic [31:0] exp);
    csr_q.push_back(exp);
    @(posedge clock); #1;
    rd_en = 1'b1; rw_addr = a;
    @(posedge clock); #1;
    rd_en = 1'b0;
    wait_idle();
  endtask

  task automatic do_req(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] op,
                        input logic [1:0] pv, input logic al, input logic ht,
                        input logic [3:0] ix, input int lat, input bit push,
                        input bit wait_done);
    int n = 0;
    exp_t e;
    e.allow = al; e.hit = ht; e.idx = ix; e.lat = lat;
    if (push) exp_q.push_back(e);
    @(posedge clock); #1;
    req_valid = 1'b1; addr = a; size = sz; oper = op; priv_mode = pv;
    @(negedge clock);
    while (!req_ready && (n < 100)) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check(1'b0, "accept_timeout", 32'(req_ready), 32'h1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (wait_done) wait_idle();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int cnt;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    check(req_ready == 1'b1, "rst_req_ready", 32'(req_ready), 32'h1);
    check(resp_valid == 1'b0, "rst_resp_valid", 32'(resp_valid), 32'h0);
    check({resp_allow, resp_hit, resp_idx} == 6'd0, "rst_resp_fields",
          32'({resp_allow, resp_hit, resp_idx}), 32'h0);
    check(rdata == 32'h0, "rst_rdata", rdata, 32'h0);
    csr_read(CSR_PMPCFG0, 32'h0);
    csr_read(CSR_PMPADDR0, 32'h0);

    // Entry 0: TOR [0, 0x1000), execute only
    csr_write(CSR_PMPADDR0, 32'h0000_0400);
    csr_write(CSR_PMPCFG0, 32'h0000_000C);
    csr_read(CSR_PMPCFG0, 32'h0000_000C);
    csr_read(CSR_PMPADDR0, 32'h0000_0400);
    csr_read(32'h0000_0123, 32'h0);
    do_req(32'h0000_0FFC, 2'd2, OPER_EXECUTE, PRIV_U, 1'b1, 1'b1, 4'd0, 2, 1'b1, 1'b1);
    do_req(32'h0000_0FFE, 2'd2, OPER_READ,    PRIV_U, 1'b0, 1'b1, 4'd0, 2, 1'b1, 1'b1);
    do_req(32'h0000_0100, 2'd0, OPER_READ,    PRIV_U, 1'b0, 1'b1, 4'd0, 2, 1'b1, 1'b1);
    do_req(32'h0000_0100, 2'd1, OPER_READ,    PRIV_M, 1'b1, 1'b1, 4'd0, 2, 1'b1, 1'b1);
    do_req(32'h0000_0100, 2'd3, OPER_READ,    PRIV_M, 1'b0, 1'b0, 4'd0, 1, 1'b1, 1'b1);
    do_req(32'h0000_0100, 2'd0, 2'b11,        PRIV_M, 1'b0, 1'b0, 4'd0, 1, 1'b1, 1'b1);

    // WARL: write-only collapses to no access, R+W kept
    csr_write(CSR_PMPCFG0 + 32'd1, 32'h0000_0302);
    csr_read(CSR_PMPCFG0 + 32'd1, 32'h0000_0300);

    // Locked TOR entry 5 freezes pmpaddr4
    csr_write(CSR_PMPADDR0 + 32'd4, 32'h0000_0050);
    csr_write(CSR_PMPCFG0 + 32'd1, 32'h0000_8800);
    csr_write(CSR_PMPADDR0 + 32'd4, 32'h0000_0060);
    csr_read(CSR_PMPADDR0 + 32'd4, 32'h0000_0050);
    csr_read(CSR_PMPCFG0 + 32'd1, 32'h0000_8800);

    // Entry 3: locked NAPOT 0x2000..0x2FFF, read only
    csr_write(CSR_PMPADDR0 + 32'd3, 32'h0000_09FF);
    csr_write(CSR_PMPCFG0, 32'h9900_000C);
    csr_write(CSR_PMPADDR0 + 32'd3, 32'h0000_0123);
    csr_write(CSR_PMPCFG0, 32'h0000_000F);
    csr_read(CSR_PMPADDR0 + 32'd3, 32'h0000_09FF);
    csr_read(CSR_PMPCFG0, 32'h9900_000F);
    do_req(32'h0000_2100, 2'd2, OPER_WRITE, PRIV_M, 1'b0, 1'b1, 4'd3, 5, 1'b1, 1'b1);
    do_req(32'h0000_2FFC, 2'd2, OPER_READ,  PRIV_M, 1'b1, 1'b1, 4'd3, 5, 1'b1, 1'b1);
    do_req(32'h0000_2FFE, 2'd2, OPER_READ,  PRIV_U, 1'b0, 1'b1, 4'd3, 5, 1'b1, 1'b1);
    do_req(32'h0000_0FF0, 2'd1, OPER_WRITE, PRIV_U, 1'b1, 1'b1, 4'd0, 2, 1'b1, 1'b1);
    do_req(32'h0000_4000, 2'd0, OPER_READ,  PRIV_M, 1'b1, 1'b0, 4'd0, 17, 1'b1, 1'b1);
    do_req(32'h0000_4000, 2'd0, OPER_READ,  PRIV_U, 1'b0, 1'b0, 4'd0, 17, 1'b1, 1'b1);

    // Back-to-back requests
    do_req(32'h0000_0FFC, 2'd2, OPER_EXECUTE, PRIV_U, 1'b1, 1'b1, 4'd0, 2, 1'b1, 1'b0);
    do_req(32'h0000_2000, 2'd2, OPER_EXECUTE, PRIV_S, 1'b0, 1'b1, 4'd3, 5, 1'b1, 1'b1);

    // Backpressure: response held for 5 cycles then released
    @(posedge clock); #1 resp_ready = 1'b0;
    do_req(32'h0000_2FFC, 2'd2, OPER_READ, PRIV_M, 1'b1, 1'b1, 4'd3, 5, 1'b1, 1'b0);
    n = 0;
    while (!resp_valid && (n < 50)) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check(1'b0, "bp_resp_timeout", 32'(resp_valid), 32'h1);
    repeat (5) @(negedge clock);
    @(posedge clock); #1 resp_ready = 1'b1;
    @(posedge clock); #1 resp_ready = 1'b0;
    @(negedge clock);
    check(req_ready == 1'b1, "bp_idle_ready", 32'(req_ready), 32'h1);
    check(resp_valid == 1'b0, "bp_idle_valid", 32'(resp_valid), 32'h0);
    resp_ready = 1'b1;
    wait_idle();

    // Reset with a simultaneous write clears locked state
    @(posedge clock); #1;
    reset = 1'b1; wr_en = 1'b1; rw_addr = CSR_PMPCFG0; wdata = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    reset = 1'b0; wr_en = 1'b0;
    csr_read(CSR_PMPCFG0, 32'h0);
    csr_read(CSR_PMPADDR0 + 32'd3, 32'h0);
    csr_read(CSR_PMPCFG0 + 32'd1, 32'h0);
    do_req(32'h8000_0000, 2'd2, OPER_READ, PRIV_M, 1'b1, 1'b0, 4'd0, 17, 1'b1, 1'b1);
    do_req(32'h8000_0000, 2'd2, OPER_READ, PRIV_S, 1'b0, 1'b0, 4'd0, 17, 1'b1, 1'b1);

    // Reset during SCAN aborts the request silently
    do_req(32'h8000_0000, 2'd2, OPER_READ, PRIV_M, 1'b1, 1'b0, 4'd0, 17, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check(req_ready == 1'b1, "abort_req_ready", 32'(req_ready), 32'h1);
    check(resp_valid == 1'b0, "abort_resp_valid", 32'(resp_valid), 32'h0);
    cnt = 0;
    repeat (25) begin
      @(negedge clock);
      if (resp_valid) cnt++;
    end
    check(cnt == 0, "abort_no_response", 32'(cnt), 32'h0);
    do_req(32'h8000_0000, 2'd0, OPER_WRITE, PRIV_M, 1'b1, 1'b0, 4'd0, 17, 1'b1, 1'b1);

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
